// File: rtl/nco_axil_regs_if.sv
// AXI4-Lite bus bundle for the NCO register block (S00_AXI).
// master drives requests and slave drives responses.
interface nco_axil_regs_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [2:0]          S_AXI_AWPROT;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [2:0]          S_AXI_ARPROT;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/nco_axil_regs.sv
// AXI4-Lite register file driving the NCO configuration (4 x 32-bit R/W).
// Optional NCO_AXIL_SLVERR_EN: unmapped slots 4-7 answer SLVERR instead of OKAY.
module nco_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    nco_axil_regs_if.slave s_axi,
    output logic [31:0] nco_ctrl,
    output logic [31:0] nco_phase_inc,
    output logic [31:0] nco_phase_off,
    output logic [31:0] nco_amplitude,
    output logic        nco_cfg_update
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int IW = AW - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [3:0][DW-1:0] regs;

    logic          aw_lat, w_lat;
    logic [IW-1:0] aw_idx_q;
    logic [DW-1:0] w_data_q;
    logic [SW-1:0] w_strb_q;
    logic          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [DW-1:0] rdata_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
    logic aw_lat_n, w_lat_n, bvalid_n, rvalid_n;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [DW-1:0] wr_data, rd_data;
    logic [SW-1:0] wr_strb;
    logic          wr_mapped, rd_mapped;
    logic [1:0]    wr_resp, rd_resp;

    assign aw_hs = s_axi.S_AXI_AWVALID & awready_q;
    assign w_hs  = s_axi.S_AXI_WVALID  & wready_q;
    assign b_hs  = bvalid_q & s_axi.S_AXI_BREADY;
    assign ar_hs = s_axi.S_AXI_ARVALID & arready_q;
    assign r_hs  = rvalid_q & s_axi.S_AXI_RREADY;

    // Take each write half from its latch if already captured, else straight off the bus,
    // so a same-cycle AW+W commits on that very edge.
    assign wr_idx    = aw_lat ? aw_idx_q : s_axi.S_AXI_AWADDR[AW-1:2];
    assign wr_data   = w_lat  ? w_data_q : s_axi.S_AXI_WDATA;
    assign wr_strb   = w_lat  ? w_strb_q : s_axi.S_AXI_WSTRB;
    assign wr_mapped = (wr_idx < IW'(4));
    assign commit    = (aw_lat | aw_hs) & (w_lat | w_hs) & ~bvalid_q;

    assign aw_lat_n = ~b_hs & (aw_lat | aw_hs);
    assign w_lat_n  = ~b_hs & (w_lat | w_hs);
    assign bvalid_n = ~b_hs & (bvalid_q | commit);
    assign rvalid_n = ~r_hs & (rvalid_q | ar_hs);

    assign rd_idx    = s_axi.S_AXI_ARADDR[AW-1:2];
    assign rd_mapped = (rd_idx < IW'(4));
    assign rd_data   = rd_mapped ? regs[rd_idx[1:0]] : '0;

`ifdef NCO_AXIL_SLVERR_EN
    assign wr_resp = wr_mapped ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp = rd_mapped ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
`endif

    logic unused_bits;
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                           s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0], RESP_SLVERR};

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            regs           <= '0;
            aw_lat         <= 1'b0;
            w_lat          <= 1'b0;
            aw_idx_q       <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
            awready_q      <= 1'b0;
            wready_q       <= 1'b0;
            bvalid_q       <= 1'b0;
            bresp_q        <= RESP_OKAY;
            arready_q      <= 1'b0;
            rvalid_q       <= 1'b0;
            rresp_q        <= RESP_OKAY;
            rdata_q        <= '0;
            nco_cfg_update <= 1'b0;
        end else begin
            aw_lat    <= aw_lat_n;
            w_lat     <= w_lat_n;
            bvalid_q  <= bvalid_n;
            rvalid_q  <= rvalid_n;
            awready_q <= ~aw_lat_n & ~bvalid_n;
            wready_q  <= ~w_lat_n & ~bvalid_n;
            arready_q <= ~rvalid_n;
            if (aw_hs) aw_idx_q <= s_axi.S_AXI_AWADDR[AW-1:2];
            if (w_hs) begin
                w_data_q <= s_axi.S_AXI_WDATA;
                w_strb_q <= s_axi.S_AXI_WSTRB;
            end
            nco_cfg_update <= commit & wr_mapped;
            if (commit) begin
                bresp_q <= wr_resp;
                if (wr_mapped) begin
                    for (int b = 0; b < SW; b++)
                        if (wr_strb[b]) regs[wr_idx[1:0]][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
            // Read samples regs before this edge's commit lands: a colliding read sees the old value.
            if (ar_hs) begin
                rdata_q <= rd_data;
                rresp_q <= rd_resp;
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;

    assign nco_ctrl      = regs[0];
    assign nco_phase_inc = regs[1];
    assign nco_phase_off = regs[2];
    assign nco_amplitude = regs[3];
endmodule

// File: tb/tb_nco_axil_regs.sv
// Directed bench for nco_axil_regs: scoreboard queues hold expected B/R responses,
// a register model tracks the NCO outputs.
module tb_nco_axil_regs;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nco_axil_regs_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    logic [31:0] nco_ctrl, nco_phase_inc, nco_phase_off, nco_amplitude;
    logic        nco_cfg_update;

    nco_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESETN  (rst_n),
        .s_axi          (bus),
        .nco_ctrl       (nco_ctrl),
        .nco_phase_inc  (nco_phase_inc),
        .nco_phase_off  (nco_phase_off),
        .nco_amplitude  (nco_amplitude),
        .nco_cfg_update (nco_cfg_update)
    );

`ifdef NCO_AXIL_SLVERR_EN
    localparam logic [1:0] UNMAP_RESP = 2'b10;
`else
    localparam logic [1:0] UNMAP_RESP = 2'b00;
`endif

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    logic [31:0] model [4];
    logic [33:0] rq [$];
    logic [1:0]  bq [$];

    always @(negedge clk) if (nco_cfg_update === 1'b1) upd_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".ctrl"}, nco_ctrl,      model[0]);
        chk({tag, ".inc"},  nco_phase_inc, model[1]);
        chk({tag, ".off"},  nco_phase_off, model[2]);
        chk({tag, ".amp"},  nco_amplitude, model[3]);
    endtask

    task automatic issue_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        bit awd = 0, wd = 0, aw_f, w_f;
        int idx = int'(a[4:2]);
        @(negedge clk);
        bus.S_AXI_AWADDR = a; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s; bus.S_AXI_WVALID = 1'b1;
        if (idx < 4) begin
            bq.push_back(2'b00);
            model[idx] = merge(model[idx], d, s);
        end else bq.push_back(UNMAP_RESP);
        for (int i = 0; i < 50; i++) begin
            aw_f = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_f  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge clk); #1;
            if (aw_f) begin bus.S_AXI_AWVALID = 1'b0; awd = 1; end
            if (w_f)  begin bus.S_AXI_WVALID = 1'b0;  wd = 1;  end
            if (awd && wd) break;
            @(negedge clk);
        end
        if (!(awd && wd)) begin
            timeout("wr_handshake");
            bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        end
    endtask

    task automatic collect_b(input string tag);
        bit got = 0;
        logic [1:0] exp;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.S_AXI_BVALID) begin got = 1; break; end
        end
        if (!got) timeout({tag, ".bvalid"});
        else begin
            exp = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
            chk({tag, ".bresp"}, {30'd0, bus.S_AXI_BRESP}, {30'd0, exp});
            bus.S_AXI_BREADY = 1'b1;
            @(posedge clk); #1;
            bus.S_AXI_BREADY = 1'b0;
        end
    endtask

    task automatic issue_rd(input logic [4:0] a);
        bit done = 0, f;
        int idx = int'(a[4:2]);
        @(negedge clk);
        bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1;
        if (idx < 4) rq.push_back({2'b00, model[idx]});
        else rq.push_back({UNMAP_RESP, 32'd0});
        for (int i = 0; i < 50; i++) begin
            f = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
            @(posedge clk); #1;
            if (f) begin bus.S_AXI_ARVALID = 1'b0; done = 1; break; end
            @(negedge clk);
        end
        if (!done) begin timeout("rd_handshake"); bus.S_AXI_ARVALID = 1'b0; end
    endtask

    task automatic collect_r(input string tag);
        bit got = 0;
        logic [33:0] exp;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.S_AXI_RVALID) begin got = 1; break; end
        end
        if (!got) timeout({tag, ".rvalid"});
        else begin
            exp = (rq.size() > 0) ? rq.pop_front() : 34'bx;
            chk({tag, ".rdata"}, bus.S_AXI_RDATA, exp[31:0]);
            chk({tag, ".rresp"}, {30'd0, bus.S_AXI_RRESP}, {30'd0, exp[33:32]});
            bus.S_AXI_RREADY = 1'b1;
            @(posedge clk); #1;
            bus.S_AXI_RREADY = 1'b0;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                      input string tag);
        issue_wr(a, d, s);
        collect_b(tag);
    endtask

    task automatic rd(input logic [4:0] a, input string tag);
        issue_rd(a);
        collect_r(tag);
    endtask

    initial begin
        int u0;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = '0;

        // Reset state
        #12;
        chk("rst.awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
        chk("rst.wready",  {31'd0, bus.S_AXI_WREADY},  32'd0);
        chk("rst.arready", {31'd0, bus.S_AXI_ARREADY}, 32'd0);
        chk("rst.bvalid",  {31'd0, bus.S_AXI_BVALID},  32'd0);
        chk("rst.rvalid",  {31'd0, bus.S_AXI_RVALID},  32'd0);
        chk("rst.update",  {31'd0, nco_cfg_update},    32'd0);
        check_outs("rst");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rel.awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
        chk("rel.wready",  {31'd0, bus.S_AXI_WREADY},  32'd1);
        chk("rel.arready", {31'd0, bus.S_AXI_ARREADY}, 32'd1);

        // Basic write/readback of all four registers
        u0 = upd_cnt;
        wr(5'h00, 32'h1, 4'hF, "t1.w0");
        wr(5'h04, 32'h2, 4'hF, "t1.w1");
        wr(5'h08, 32'h3, 4'hF, "t1.w2");
        wr(5'h0C, 32'h4, 4'hF, "t1.w3");
        rd(5'h00, "t1.r0"); rd(5'h04, "t1.r1"); rd(5'h08, "t1.r2"); rd(5'h0C, "t1.r3");
        check_outs("t1");
        chk("t1.updates", upd_cnt - u0, 32'd4);

        // Byte strobes
        wr(5'h04, 32'hAABBCCDD, 4'hF, "t2.full");
        wr(5'h04, 32'h11223344, 4'b0101, "t2.strb");
        rd(5'h04, "t2.rd");
        chk("t2.inc_const", nco_phase_inc, 32'hAA22CC44);

        // AW three cycles ahead of W, BREADY held off
        u0 = upd_cnt;
        @(negedge clk);
        bus.S_AXI_AWADDR = 5'h0C; bus.S_AXI_AWVALID = 1'b1;
        chk("t3.awready0", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
        bq.push_back(2'b00);
        @(posedge clk); #1; bus.S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3.aw_wait.awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
            chk("t3.aw_wait.wready",  {31'd0, bus.S_AXI_WREADY},  32'd1);
            chk("t3.aw_wait.bvalid",  {31'd0, bus.S_AXI_BVALID},  32'd0);
        end
        bus.S_AXI_WDATA = 32'h0000_00A5; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        model[3] = 32'h0000_00A5;
        @(posedge clk); #1; bus.S_AXI_WVALID = 1'b0;
        @(negedge clk);
        chk("t3.bvalid_n1", {31'd0, bus.S_AXI_BVALID}, 32'd1);
        chk("t3.update",    {31'd0, nco_cfg_update},   32'd1);
        check_outs("t3");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3.hold.bvalid",  {31'd0, bus.S_AXI_BVALID},  32'd1);
            chk("t3.hold.awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
            chk("t3.hold.wready",  {31'd0, bus.S_AXI_WREADY},  32'd0);
        end
        collect_b("t3.b");
        @(negedge clk);
        chk("t3.post.awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
        chk("t3.post.wready",  {31'd0, bus.S_AXI_WREADY},  32'd1);
        chk("t3.post.bvalid",  {31'd0, bus.S_AXI_BVALID},  32'd0);
        chk("t3.updates", upd_cnt - u0, 32'd1);

        // Read of 0x08 in the same cycle as a write to it returns the old value
        @(negedge clk);
        chk("t4.awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
        chk("t4.wready",  {31'd0, bus.S_AXI_WREADY},  32'd1);
        chk("t4.arready", {31'd0, bus.S_AXI_ARREADY}, 32'd1);
        bus.S_AXI_AWADDR = 5'h08; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h5; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = 5'h08; bus.S_AXI_ARVALID = 1'b1;
        rq.push_back({2'b00, 32'h3});
        bq.push_back(2'b00);
        model[2] = 32'h5;
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        collect_b("t4.b");
        collect_r("t4.r_old");
        rd(5'h08, "t4.r_new");

        // Unmapped slot 0x14
        u0 = upd_cnt;
        wr(5'h14, 32'hFFFFFFFF, 4'hF, "t5.w");
        rd(5'h14, "t5.r");
        check_outs("t5");
        chk("t5.updates", upd_cnt - u0, 32'd0);

        // Reset while a write response is pending
        bus.S_AXI_BREADY = 1'b0;
        issue_wr(5'h00, 32'h7, 4'hF);
        @(negedge clk);
        chk("t6.bvalid_pre", {31'd0, bus.S_AXI_BVALID}, 32'd1);
        chk("t6.ctrl_pre",   nco_ctrl, 32'h7);
        #2 rst_n = 1'b0;
        #1;
        chk("t6.bvalid_rst",  {31'd0, bus.S_AXI_BVALID},  32'd0);
        chk("t6.ctrl_rst",    nco_ctrl, 32'd0);
        chk("t6.awready_rst", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
        bq.delete();
        for (int i = 0; i < 4; i++) model[i] = '0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("t6.awready_rel", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
        chk("t6.bvalid_rel",  {31'd0, bus.S_AXI_BVALID},  32'd0);
        rd(5'h00, "t6.r0");
        rd(5'h04, "t6.r1");
        check_outs("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/nco_axil_regs.md
Name: nco_axil_regs

Overview:
AXI4-Lite slave (responder) register file for the NCO IP's S00_AXI port; the other end of the AXI4-Lite master that programs the NCO. It terminates single-beat AXI4-Lite writes and reads into four 32-bit R/W configuration registers and drives them to the NCO datapath. It also emits a one-cycle update strobe so the NCO core can load new settings synchronously.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes 8 word slots, 0x00-0x1C.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset, asynchronous, active-low
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
nco_ctrl  out  32  reg0 (0x00): bit0 enable, bit1 phase clear, others reserved but stored
nco_phase_inc  out  32  reg1 (0x04)
nco_phase_off  out  32  reg2 (0x08)
nco_amplitude  out  32  reg3 (0x0C)
nco_cfg_update  out  1  one-cycle pulse per committed mapped write

Behaviour:
- Reset: one clock, S_AXI_ARESETN asynchronous, active-low. All outputs and reg0-reg3 are 0 while reset is asserted; AWREADY/WREADY/ARREADY rise on the first clock edge after release.
- Decode: word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]; ADDR[1:0] ignored. Slots 0-3 are mapped; slots 4-7 (0x10-0x1C) are unmapped.
- Write channel, independent capture:
  - AWREADY is high when no address is latched and BVALID=0.
  - WREADY is high when no data is latched and BVALID=0.
  - AW and W may arrive in either order or the same cycle. Each is latched on its handshake, and its READY drops the next cycle.
- Write commit:
  - Occurs the cycle after both address and data are latched. For each WSTRB[n]=1, byte n of the addressed register takes WDATA byte n; bytes with strobe 0 are unchanged.
  - BVALID rises in the commit cycle. BRESP=OKAY (2'b00).
  - nco_cfg_update pulses high in the same cycle, mapped slots only.
- BVALID holds until BREADY. Both latches clear on B handshake, and AWREADY/WREADY return high the next cycle. Minimum write latency: AW+W handshake at cycle N, BVALID at N+1.
- Read channel:
  - ARREADY is high when RVALID=0.
  - On AR handshake (cycle N), RDATA is captured and RVALID=1 at N+1.
  - ARREADY is low while RVALID=1. RVALID and RDATA hold until RREADY; ARREADY returns high the cycle after the R handshake. RRESP=OKAY.
- Collision: if the AR handshake falls in a write-commit cycle to the same register, RDATA returns the pre-write value.
- Register outputs update in the commit cycle and are always registered (no combinational path from the bus).
- Reset mid-transaction: all latched state, BVALID and RVALID are dropped immediately, and registers return to 0. No response is issued for the aborted transfer.
- Exactly one write and one read outstanding.

Optional Feature:
Macro NCO_AXIL_SLVERR_EN.
- Defined: accesses to unmapped slots 4-7 complete with BRESP/RRESP = SLVERR (2'b10). Writes do not modify registers and produce no nco_cfg_update pulse; reads return RDATA=0.
- Undefined: unmapped writes are ignored with BRESP=OKAY, and unmapped reads return 0 with RRESP=OKAY.
- Timing is identical in both builds.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read back -> RDATA 0x1..0x4, all RESP=OKAY, outputs match, four nco_cfg_update pulses.
- reg1=0xAABBCCDD, then write 0x11223344 with WSTRB=4'b0101 to 0x04 -> reads 0xAA22CC44.
- AWVALID 3 cycles before WVALID, with BREADY held low 5 cycles -> single commit, BVALID holds, AWREADY/WREADY stay low until the B handshake.
- Same-cycle write 0x5 and read of 0x08 (old value 0x3) -> RDATA=0x3; a subsequent read returns 0x5.
- Write 0xFFFFFFFF to 0x14, then read 0x14 -> with macro BRESP=RRESP=2'b10 and RDATA=0; without macro both OKAY and RDATA=0; reg0-reg3 unchanged, no update pulse.
- Assert reset while BVALID=1 after a write of 0x7 to 0x00 -> BVALID=0 and nco_ctrl=0 immediately; after release AWREADY=1 and reads return 0.
